// File: rtl/serial_word_tx_pkg.sv
// Shared definitions for the serial word transmitter: FSM state encoding
// and the default word length.
package serial_word_tx_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/word_shifter.sv
// Shift register plus bit counter: loads a word, walks it out one bit per
// clock toward the selected end, and flags the first and last bit positions.
module word_shifter
  import serial_word_tx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             bit_out,
  output logic             first,
  output logic             last
);

  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;

  // Zero fill keeps the line quiet once the last real bit has left.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= data;
      cnt   <= '0;
    end else if (shift) begin
      if (MSB_FIRST) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
      end else begin
        shreg <= {1'b0, shreg[WIDTH-1:1]};
      end
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_out = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign first   = (cnt == '0);
  assign last    = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial front end: one-word skid buffer behind a valid/ready
// handshake, feeding a shifter that emits framed words with sof/eow markers.
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             eow,
  output logic             busy
);

  state_t           state;
  logic             buf_full;
  logic [WIDTH-1:0] word_buf;
  logic             bit_out;
  logic             first;
  logic             last;
  logic             shifting;
  logic             accept;
  logic             load;
  logic             shift;

  assign shifting  = (state == ST_SHIFT);
  assign din_ready = !buf_full && !rst;
  assign accept    = din_valid && din_ready;
  // Reloading on the last bit is what makes back-to-back words gap-free.
  assign load      = buf_full && (!shifting || last);
  assign shift     = shifting && !load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      buf_full <= 1'b0;
      word_buf <= '0;
    end else begin
      if (accept) begin
        word_buf <= din;
        buf_full <= 1'b1;
      end
      if (load) begin
        state    <= ST_SHIFT;
        buf_full <= 1'b0;
      end else if (shifting && last) begin
        state <= ST_IDLE;
      end
    end
  end

  word_shifter #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST),
    .CNT_W    (CNT_W)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .shift  (shift),
    .data   (word_buf),
    .bit_out(bit_out),
    .first  (first),
    .last   (last)
  );

  assign sout       = shifting && bit_out;
  assign sout_valid = shifting;
  assign sof        = shifting && first;
  assign eow        = shifting && last;
  assign busy       = shifting || buf_full;

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
Parallel-to-serial front end for the serial parity classifier FSM. It accepts WIDTH-bit words over a valid/ready handshake and holds one word in a skid buffer. Each word is shifted out one bit per clock on a single serial line, with start-of-word and end-of-word markers. The sof marker is intended to drive the downstream classifier's synchronous reset, so the classifier's A/B/C/D outputs after eow describe exactly one word.

Parameters:
WIDTH, 8, word length in bits (>=2)
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first
CNT_W, $clog2(WIDTH), width of the bit counter (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
din  in  WIDTH  parallel word
din_valid  in  1  din is presented
din_ready  out  1  block can accept a word this cycle
sout  out  1  serial data bit
sout_valid  out  1  sout carries a live bit this cycle
sof  out  1  current bit is the first bit of a word
eow  out  1  current bit is the last bit of a word
busy  out  1  shifter active or buffer occupied

Behaviour:
- Reset and clock: reset rst, synchronous, active-high; clock clk. rst has priority over all other activity.
- Reset values after a reset edge:
  - state=IDLE; buf_full=0; cnt=0; shreg=0.
  - sout=0, sout_valid=0, sof=0, eow=0, busy=0.
  - din_ready=0 while rst is high and 1 on the first cycle after rst is released.
- Output timing:
  - din_ready = !buf_full && !rst.
  - All other outputs decode registered state only. There is no combinational path from din or din_valid to any output.
- Accept: at an edge where din_valid && din_ready, do buf<=din and buf_full<=1.
  - din_ready requires an empty buffer, so accept and load never occur on the same edge.
- States: IDLE and SHIFT.
- Load condition: buf_full && (state==IDLE || (state==SHIFT && cnt==WIDTH-1)).
  - On load: shreg<=buf, cnt<=0, state<=SHIFT, buf_full<=0.
- Shift (state==SHIFT):
  - sout = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0].
  - sout_valid=1; sof=(cnt==0); eow=(cnt==WIDTH-1).
  - Each edge, shreg shifts toward the output end with zero fill, and cnt increments.
  - At cnt==WIDTH-1: reload if buf_full, otherwise go to IDLE.
- Idle (state==IDLE): sout=0, sout_valid=0, sof=0, eow=0.
- Latency: a word accepted at edge k is loaded at edge k+1. Its first bit (with sof) is valid in the cycle after edge k+1, and its last bit (with eow) WIDTH-1 cycles later.
- Throughput: continuous input gives gap-free output of one word per WIDTH cycles. eow of word n is immediately followed by sof of word n+1.
- Backpressure: din_ready stays low from accept until the word is loaded into shreg. din must be held by the source while not accepted.
- busy = (state==SHIFT) || buf_full.
- Reset mid-word: the bit stream aborts, and the partial word plus any buffered word are discarded. No eow is issued for the aborted word.
- Upstream rules:
  - din_valid may drop without being accepted; nothing is captured.
  - Words with X on din while din_valid=0 are ignored.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=1'b0, ST_SHIFT=1'b1), and the default WIDTH.
- One sub-module is natural: word_shifter (shreg plus cnt, with load/shift controls and sof/eow decode).
- The handshake buffer and the FSM stay in the top.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1:
  - Stimulus: din=8'hA5 accepted at edge k.
  - Response: sout=1,0,1,0,0,1,0,1 on 8 consecutive cycles starting after edge k+1; sof on bit 1 only; eow on bit 8 only; then sout_valid=0 and busy=0.
- Back-to-back:
  - Stimulus: 8'hA5 then 8'h3C with din_valid held high.
  - Response: 16 contiguous sout_valid cycles with sequence 10100101 00111100; eow of word 1 adjacent to sof of word 2; din_ready low for exactly the cycles the buffer is full.
- Backpressure:
  - Stimulus: three words offered continuously.
  - Response: word 3 is not accepted until word 2 loads, i.e. at the edge carrying eow of word 1 plus one; no word is lost or duplicated.
- MSB_FIRST=0:
  - Stimulus: din=8'h01.
  - Response: sout=1 on the sof cycle, 0 for the remaining 7 bits.
- Reset mid-word:
  - Stimulus: rst asserted after 3 bits of 8'hFF while 8'h0F is buffered.
  - Response: the next cycle shows sout_valid=0, busy=0, din_ready=0; after release din_ready=1; 8'h0F is never transmitted.
- Downstream integration:
  - Stimulus: sof drives the classifier's reset; din=8'h03.
  - Response: after eow, the classifier indicates even ones / even zeros (A=1, B=C=D=0).
